avalon_burst_master: RTL and testbench

- Avalon-MM bus initiator for the neural network accelerator.
- Turns one local command (read or write, start address, beat count) into a single Avalon-MM transaction, including waitrequest stalls, burstcount/beginbursttransfer and pipelined readdatavalid returns.
- Drives the accelerator's Avalon slave from on-chip logic (self-test, DMA of pixels/weights) in place of the bench-driven master.

---
 rtl/avalon_burst_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_avalon_burst_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_master.sv
// Avalon-MM burst initiator for the NN accelerator.
// Converts one local command (read or write, start address, beat count) into
// a single Avalon-MM burst. Writes stream through a one-word holding register
// so the source can run one beat per clock. Reads issue a single request and
// count pipelined readdatavalid returns. A done pulse closes every
// transaction, and resp_err reports any non-OKAY beat.

module avalon_burst_master #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 10
) (
    input  logic               clk,
    input  logic               n_rst,
    // local command side
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_address,
    input  logic [BURST_W-1:0] cmd_burstcount,
    // local write-data source
    input  logic [DATA_W-1:0]  wdata,
    input  logic               wdata_valid,
    output logic               wdata_ready,
    // local read-data sink and status
    output logic [DATA_W-1:0]  rdata,
    output logic               rdata_valid,
    output logic               done,
    output logic               resp_err,
    // Avalon-MM master side
    output logic [ADDR_W-1:0]  address,
    output logic               read,
    output logic               write,
    output logic               beginbursttransfer,
    output logic [BURST_W-1:0] burstcount,
    output logic [DATA_W-1:0]  writedata,
    input  logic               waitrequest,
    input  logic [DATA_W-1:0]  readdata,
    input  logic               readdatavalid,
    input  logic [1:0]         response
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_BURST = 3'd1;
    localparam logic [2:0] ST_RD_REQ   = 3'd2;
    localparam logic [2:0] ST_RD_DATA  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic [BURST_W-1:0] BEAT_ZERO = {BURST_W{1'b0}};
    localparam logic [BURST_W-1:0] BEAT_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

    // state and datapath registers
    logic [2:0]         state_q,      state_d;
    logic [BURST_W-1:0] beats_q,      beats_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic [BURST_W-1:0] bcnt_q,       bcnt_d;
    logic [DATA_W-1:0]  hold_q,       hold_d;
    logic               hold_full_q,  hold_full_d;
    logic               resp_err_q,   resp_err_d;
    logic [DATA_W-1:0]  rdata_q,      rdata_d;
    logic               rdata_vld_q;
    logic               cmd_ready_q;
    logic               done_q;
    logic               read_q;
    logic               bbt_q;

    // per-cycle strobes
    logic               cmd_acc_s;
    logic               wr_beat_s;
    logic               rd_beat_s;
    logic               grant_s;
    logic               last_beat_s;
    logic               wdata_ready_s;
    logic               hold_load_s;
    logic               resp_bad_s;
    logic [BURST_W-1:0] cmd_beats_s;

    // Decode handshakes: command accept, write/read beats, read grant, source pull
    always_comb begin
        cmd_acc_s   = (state_q == ST_IDLE) && cmd_valid;
        wr_beat_s   = (state_q == ST_WR_BURST) && hold_full_q && !waitrequest;
        // a zero-latency slave may return data in the same cycle as the grant
        rd_beat_s   = readdatavalid &&
                      ((state_q == ST_RD_REQ) || (state_q == ST_RD_DATA));
        grant_s     = (state_q == ST_RD_REQ) && read_q && !waitrequest;
        last_beat_s = (beats_q == BEAT_ONE);
        // refill in the cycle the held beat leaves, unless that was the last beat
        if (state_q == ST_WR_BURST) begin
            wdata_ready_s = !hold_full_q || (wr_beat_s && !last_beat_s);
        end else begin
            wdata_ready_s = 1'b0;
        end
        hold_load_s = wdata_ready_s && wdata_valid;
        resp_bad_s  = (response != 2'b00) && (wr_beat_s || rd_beat_s);
        if (cmd_burstcount == BEAT_ZERO) begin
            cmd_beats_s = BEAT_ONE;
        end else begin
            cmd_beats_s = cmd_burstcount;
        end
    end

    // Transaction sequencing and remaining-beat counter
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc_s) begin
                    beats_d = cmd_beats_s;
                    state_d = cmd_write ? ST_WR_BURST : ST_RD_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_BURST: begin
                if (wr_beat_s) begin
                    beats_d = beats_q - BEAT_ONE;
                    state_d = last_beat_s ? ST_DONE : ST_WR_BURST;
                end else begin
                    state_d = ST_WR_BURST;
                end
            end
            ST_RD_REQ: begin
                if (rd_beat_s) begin
                    beats_d = beats_q - BEAT_ONE;
                end else begin
                    beats_d = beats_q;
                end
                if (rd_beat_s && last_beat_s) begin
                    state_d = ST_DONE;
                end else if (grant_s) begin
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                if (rd_beat_s) begin
                    beats_d = beats_q - BEAT_ONE;
                    state_d = last_beat_s ? ST_DONE : ST_RD_DATA;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                beats_d = BEAT_ZERO;
            end
        endcase
    end

    // Command latches, write holding register, error flag and read capture
    always_comb begin
        if (cmd_acc_s) begin
            addr_d = cmd_address;
            bcnt_d = cmd_beats_s;
        end else begin
            addr_d = addr_q;
            bcnt_d = bcnt_q;
        end

        if (hold_load_s) begin
            hold_d      = wdata;
            hold_full_d = 1'b1;
        end else if (wr_beat_s) begin
            hold_d      = hold_q;
            hold_full_d = 1'b0;
        end else begin
            hold_d      = hold_q;
            hold_full_d = hold_full_q;
        end

        // sticky for the current command, cleared only by the next accept
        if (cmd_acc_s) begin
            resp_err_d = 1'b0;
        end else if (resp_bad_s) begin
            resp_err_d = 1'b1;
        end else begin
            resp_err_d = resp_err_q;
        end

        if (rd_beat_s) begin
            rdata_d = readdata;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, counters and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            beats_q     <= BEAT_ZERO;
            addr_q      <= {ADDR_W{1'b0}};
            bcnt_q      <= BEAT_ZERO;
            hold_q      <= {DATA_W{1'b0}};
            hold_full_q <= 1'b0;
            resp_err_q  <= 1'b0;
            rdata_q     <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            addr_q      <= addr_d;
            bcnt_q      <= bcnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            resp_err_q  <= resp_err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Registered control outputs, decoded from the next state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            read_q      <= 1'b0;
            bbt_q       <= 1'b0;
            rdata_vld_q <= 1'b0;
        end else begin
            cmd_ready_q <= (state_d == ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            read_q      <= (state_d == ST_RD_REQ);
            bbt_q       <= cmd_acc_s;
            rdata_vld_q <= rd_beat_s;
        end
    end

    assign cmd_ready          = cmd_ready_q;
    assign wdata_ready        = wdata_ready_s;
    assign rdata              = rdata_q;
    assign rdata_valid        = rdata_vld_q;
    assign done               = done_q;
    assign resp_err           = resp_err_q;
    assign address            = addr_q;
    assign read               = read_q;
    assign write              = hold_full_q;
    assign beginbursttransfer = bbt_q;
    assign burstcount         = bcnt_q;
    assign writedata          = hold_q;

endmodule

// File: tb/tb_avalon_burst_master.sv
// Directed bench for avalon_burst_master: a cycle-vector table for a stalled
// single write, then hand-written sequences for bursts, error response,
// zero-latency read and reset mid-burst.

module tb_avalon_burst_master;

    logic        clk;
    logic        n_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [10:0] cmd_address;
    logic [9:0]  cmd_burstcount;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        resp_err;
    logic [10:0] address;
    logic        read;
    logic        write;
    logic        beginbursttransfer;
    logic [9:0]  burstcount;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [1:0]  response;

    int n_pass  = 0;
    int n_total = 0;

    avalon_burst_master dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_address        (cmd_address),
        .cmd_burstcount     (cmd_burstcount),
        .wdata              (wdata),
        .wdata_valid        (wdata_valid),
        .wdata_ready        (wdata_ready),
        .rdata              (rdata),
        .rdata_valid        (rdata_valid),
        .done               (done),
        .resp_err           (resp_err),
        .address            (address),
        .read               (read),
        .write              (write),
        .beginbursttransfer (beginbursttransfer),
        .burstcount         (burstcount),
        .writedata          (writedata),
        .waitrequest        (waitrequest),
        .readdata           (readdata),
        .readdatavalid      (readdatavalid),
        .response           (response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cmd_valid;
        logic        cmd_write;
        logic [10:0] cmd_address;
        logic [9:0]  cmd_burstcount;
        logic [31:0] wdata;
        logic        wdata_valid;
        logic        waitrequest;
        logic        e_cmd_ready;
        logic        e_wdata_ready;
        logic        e_write;
        logic        e_bbt;
        logic        e_done;
        logic        e_resp_err;
        logic [10:0] e_address;
        logic [9:0]  e_burstcount;
        logic [31:0] e_writedata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [10:0] a, input int n, input int err_beat,
                            input int starve_at, input logic exp_err);
        int idx = 0, beats = 0, st_cnt = 0, bbt_cnt = 0;
        int bad_data = 0, bc_bad = 0, gap = 0;
        bit got_done = 1'b0;
        bit acc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = a; cmd_burstcount = 10'(n);
        wdata_valid = 1'b0; waitrequest = 1'b0; response = 2'b00;
        #1 chk("wr_cmd_ready", cmd_ready, 1'b1);
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (cyc == 0) chk("wr_resp_err_clear", resp_err, 1'b0);
            if (beginbursttransfer) bbt_cnt++;
            if (done) begin
                got_done = 1'b1;
                chk("wr_resp_err_at_done", resp_err, exp_err);
                chk("wr_write_low_at_done", write, 1'b0);
            end else begin
                if (write && (burstcount !== 10'(n) || address !== a)) bc_bad++;
                if (!write && beats > 0) gap++;
                waitrequest = cyc[0];
                acc = write && !waitrequest;
                response = (acc && beats == err_beat) ? 2'b10 : 2'b00;
                if (idx < n && !(idx == starve_at && st_cnt < 2)) begin
                    wdata_valid = 1'b1;
                    wdata = 32'(2 * idx);
                end else begin
                    wdata_valid = 1'b0;
                    if (idx == starve_at) st_cnt++;
                end
                #1;
                if (acc) begin
                    if (writedata !== 32'(2 * beats)) bad_data++;
                    beats++;
                end
                if (wdata_valid && wdata_ready) idx++;
            end
        end
        wdata_valid = 1'b0; response = 2'b00; waitrequest = 1'b0;
        chk("wr_done_seen", got_done, 1'b1);
        chk("wr_beat_count", beats, n);
        chk("wr_words_pulled", idx, n);
        chk("wr_data_order_errors", bad_data, 0);
        chk("wr_addr_bcnt_unstable", bc_bad, 0);
        chk("wr_bbt_cycles", bbt_cnt, 1);
        chk("wr_write_dropped_mid_burst", gap > 0, starve_at >= 0);
    endtask

    task automatic do_read(input logic [10:0] a, input logic [9:0] bc, input int n,
                           input int wait_cycles, input bit zero_lat);
        int wcnt = 0, sent = 0, got = 0;
        int rv_bad = 0, rd_bad = 0, bad_data = 0, bbt_bad = 0;
        bit granted = 1'b0, prev_rdv = 1'b0, gap_tog = 1'b1, got_done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = a; cmd_burstcount = bc;
        waitrequest = 1'b1; readdatavalid = 1'b0; response = 2'b00;
        #1 chk("rd_cmd_ready", cmd_ready, 1'b1);
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (cyc == 0) begin
                chk("rd_resp_err_clear", resp_err, 1'b0);
                chk("rd_bbt_first", beginbursttransfer, 1'b1);
                chk("rd_burstcount", burstcount, (bc == 10'd0) ? 10'd1 : bc);
            end else if (beginbursttransfer) begin
                bbt_bad++;
            end
            if (read !== !granted) rd_bad++;
            if (address !== a) rd_bad++;
            if (rdata_valid !== prev_rdv) rv_bad++;
            if (rdata_valid) begin
                if (rdata !== 32'(32'hA + got)) bad_data++;
                got++;
            end
            if (done) begin
                got_done = 1'b1;
                readdatavalid = 1'b0;
                waitrequest = 1'b0;
            end else begin
                readdatavalid = 1'b0;
                if (!granted) begin
                    if (wcnt < wait_cycles) begin
                        waitrequest = 1'b1;
                        wcnt++;
                    end else begin
                        waitrequest = 1'b0;
                        granted = 1'b1;
                        if (zero_lat) begin
                            readdatavalid = 1'b1;
                            readdata = 32'(32'hA + sent);
                            sent++;
                        end
                    end
                end else begin
                    waitrequest = 1'b1;
                    if (sent < n && gap_tog) begin
                        readdatavalid = 1'b1;
                        readdata = 32'(32'hA + sent);
                        sent++;
                    end
                    gap_tog = !gap_tog;
                end
                prev_rdv = readdatavalid;
            end
        end
        chk("rd_done_seen", got_done, 1'b1);
        chk("rd_beats_returned", got, n);
        chk("rd_rdata_valid_timing", rv_bad, 0);
        chk("rd_read_or_addr_errors", rd_bad, 0);
        chk("rd_data_order_errors", bad_data, 0);
        chk("rd_bbt_extra", bbt_bad, 0);
    endtask

    initial begin
        // inputs                                             | expected outputs
        // cv    cw    addr     bc     wdata  wv    wr        | rdy  wrdy write bbt done err addr bc wd
        vecs[0] = '{1'b1, 1'b1, 11'h001, 10'd1, 32'h8, 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 10'd0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 11'h001, 10'd1, 32'h8, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h001, 10'd1, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 11'h001, 10'd1, 32'h8, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h001, 10'd1, 32'h8};
        vecs[3] = '{1'b0, 1'b1, 11'h001, 10'd1, 32'h8, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h001, 10'd1, 32'h8};
        vecs[4] = '{1'b0, 1'b1, 11'h001, 10'd1, 32'h8, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h001, 10'd1, 32'h8};
        vecs[5] = '{1'b0, 1'b1, 11'h001, 10'd1, 32'h8, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h001, 10'd1, 32'h8};
        vecs[6] = '{1'b0, 1'b1, 11'h001, 10'd1, 32'h8, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h001, 10'd1, 32'h8};
        vecs[7] = '{1'b0, 1'b1, 11'h001, 10'd1, 32'h8, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h001, 10'd1, 32'h8};

        n_rst = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 11'h000; cmd_burstcount = 10'd0;
        wdata = 32'h0; wdata_valid = 1'b0; waitrequest = 1'b0;
        readdata = 32'h0; readdatavalid = 1'b0; response = 2'b00;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        // single write, three stall cycles
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cmd_valid      = vecs[i].cmd_valid;
            cmd_write      = vecs[i].cmd_write;
            cmd_address    = vecs[i].cmd_address;
            cmd_burstcount = vecs[i].cmd_burstcount;
            wdata          = vecs[i].wdata;
            wdata_valid    = vecs[i].wdata_valid;
            waitrequest    = vecs[i].waitrequest;
            #1;
            chk($sformatf("v%0d_cmd_ready", i),   cmd_ready,          vecs[i].e_cmd_ready);
            chk($sformatf("v%0d_wdata_ready", i), wdata_ready,        vecs[i].e_wdata_ready);
            chk($sformatf("v%0d_write", i),       write,              vecs[i].e_write);
            chk($sformatf("v%0d_bbt", i),         beginbursttransfer, vecs[i].e_bbt);
            chk($sformatf("v%0d_done", i),        done,               vecs[i].e_done);
            chk($sformatf("v%0d_resp_err", i),    resp_err,           vecs[i].e_resp_err);
            chk($sformatf("v%0d_address", i),     address,            vecs[i].e_address);
            chk($sformatf("v%0d_burstcount", i),  burstcount,         vecs[i].e_burstcount);
            chk($sformatf("v%0d_writedata", i),   writedata,          vecs[i].e_writedata);
        end
        waitrequest = 1'b0;

        // 10-beat write, waitrequest toggling, source starves 2 cycles at word 5
        do_write(11'h000, 10, -1, 5, 1'b0);
        // 5-beat write, error response on beat 3
        do_write(11'h004, 5, 2, -1, 1'b1);
        // 4-beat read with 2 stall cycles and gaps; also checks resp_err cleared
        do_read(11'h010, 10'd4, 4, 2, 1'b0);
        // burstcount 0 with zero-latency slave
        do_read(11'h030, 10'd0, 1, 0, 1'b1);

        // reset in the middle of a read burst
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 11'h020; cmd_burstcount = 10'd4;
        waitrequest = 1'b0; readdatavalid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        readdatavalid = 1'b1; readdata = 32'h11;
        @(negedge clk);
        readdatavalid = 1'b0;
        chk("rst_pre_rdata_valid", rdata_valid, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_read", read, 1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_rdata_valid", rdata_valid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_bbt", beginbursttransfer, 1'b0);
        chk("rst_address", address, 11'h000);
        chk("rst_burstcount", burstcount, 10'd0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_wdata_ready", wdata_ready, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        readdatavalid = 1'b1; readdata = 32'h99;
        @(negedge clk);
        readdatavalid = 1'b0;
        chk("stray_rdata_valid", rdata_valid, 1'b0);
        chk("stray_done", done, 1'b0);
        chk("stray_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        chk("post_rst_no_done", done, 1'b0);

        // normal read after the abandoned one
        do_read(11'h040, 10'd3, 3, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
